// File: rtl/wb_ram_arb_pkg.sv
// -----------------------------------------------------------------------------
// wb_ram_arb_pkg
// Shared constants for the two-master Wishbone RAM arbiter:
//   - state encoding (IDLE / OWN0 / OWN1), kept as plain 2-bit constants so
//     older tools and waveform scripts that expect fixed codes still work
//   - default bus widths and the timeout counter width
// No ports (package).
// -----------------------------------------------------------------------------
package wb_ram_arb_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN0 = 2'd1;
  localparam logic [1:0] ST_OWN1 = 2'd2;

  localparam int ARB_ADDR_WIDTH = 32;
  localparam int ARB_DATA_WIDTH = 32;
  localparam int ARB_TMO_CNT_W  = 16;

endpackage

// File: rtl/wb_ram_arb_rr_pick2.sv
// -----------------------------------------------------------------------------
// rr_pick2
// Combinational two-way round-robin chooser.
// Ports:
//   req[1:0]   in   request vector, bit i = requester i
//   lastOwner  in   index of the requester granted most recently
//   pick[1:0]  out  one-hot winner, 00 when nobody requests
// On a tie the requester that did not own last time wins.
// -----------------------------------------------------------------------------
module rr_pick2
  import wb_ram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       lastOwner,
  output logic [1:0] pick
);

  always_comb begin
    pick = req;
    if (req == 2'b11) begin
      pick = lastOwner ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/wb_ram_arbiter.sv
// -----------------------------------------------------------------------------
// wb_ram_arbiter
// Two-master, one-slave round-robin arbiter for the single-ported Wishbone RAM
// bus. A grant is held for one whole transaction (until slave ack or master
// abort) and the arbiter always spends at least one IDLE cycle between
// transactions so the toggle-ack RAM sees its strobe drop.
//
// Ports:
//   clock, reset                 clock (rising edge), async active-low reset
//   m0*/m1*                      master ports: CycleStrobe, WriteEnable,
//                                Address, WriteData in; ReadData, Ack out
//   s*                           slave port: CycleStrobe, WriteEnable,
//                                Address, WriteData out; ReadData, Ack in
//   timeoutError                 (only with WB_RAM_ARB_TIMEOUT_EN) one-cycle
//                                pulse when an ack wait times out
//   grant[1:0]                   one-hot current owner, 00 when idle
//
// Optional feature macro: WB_RAM_ARB_TIMEOUT_EN
//   When defined, an owner waiting TIMEOUT_CYCLES cycles without sAck gets a
//   forced ack plus timeoutError, and the bus returns to IDLE.
// -----------------------------------------------------------------------------
module wb_ram_arbiter
  import wb_ram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = ARB_ADDR_WIDTH,
  parameter int DATA_WIDTH     = ARB_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clock,
  input  logic                  reset,

  input  logic                  m0CycleStrobe,
  input  logic                  m0WriteEnable,
  input  logic [ADDR_WIDTH-1:0] m0Address,
  input  logic [DATA_WIDTH-1:0] m0WriteData,
  output logic [DATA_WIDTH-1:0] m0ReadData,
  output logic                  m0Ack,

  input  logic                  m1CycleStrobe,
  input  logic                  m1WriteEnable,
  input  logic [ADDR_WIDTH-1:0] m1Address,
  input  logic [DATA_WIDTH-1:0] m1WriteData,
  output logic [DATA_WIDTH-1:0] m1ReadData,
  output logic                  m1Ack,

  output logic                  sCycleStrobe,
  output logic                  sWriteEnable,
  output logic [ADDR_WIDTH-1:0] sAddress,
  output logic [DATA_WIDTH-1:0] sWriteData,
  input  logic [DATA_WIDTH-1:0] sReadData,
  input  logic                  sAck,

`ifdef WB_RAM_ARB_TIMEOUT_EN
  output logic                  timeoutError,
`endif
  output logic [1:0]            grant
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("wb_ram_arbiter: TIMEOUT_CYCLES must be in 1..65535");
  end

  logic [1:0] state_q, state_d;
  logic       last_q, last_d;
  logic [1:0] pick;
  logic       own0, own1;
  logic       ownerStrobe;
  logic       timeoutHit;
  logic       ackIn;

  rr_pick2 u_pick (
    .req       ({m1CycleStrobe, m0CycleStrobe}),
    .lastOwner (last_q),
    .pick      (pick)
  );

  assign own0        = (state_q == ST_OWN0);
  assign own1        = (state_q == ST_OWN1);
  assign ownerStrobe = (own0 & m0CycleStrobe) | (own1 & m1CycleStrobe);

`ifdef WB_RAM_ARB_TIMEOUT_EN
  logic [ARB_TMO_CNT_W-1:0] cnt_q, cnt_d;

  // Counter is held at zero in IDLE, so it is already clear on entry to OWNx.
  always_comb begin
    cnt_d = '0;
    if ((own0 | own1) && !sAck && (cnt_q != {ARB_TMO_CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeoutHit   = (own0 | own1) && (cnt_q == ARB_TMO_CNT_W'(TIMEOUT_CYCLES));
  assign timeoutError = ownerStrobe & timeoutHit;
`else
  assign timeoutHit = 1'b0;
`endif

  // A timeout behaves exactly like a slave ack towards the owner.
  assign ackIn = sAck | timeoutHit;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (pick[0]) begin
          state_d = ST_OWN0;
          last_d  = 1'b0;
        end else if (pick[1]) begin
          state_d = ST_OWN1;
          last_d  = 1'b1;
        end
      end
      // Strobe drop (abort) or ack both end the transaction; abort wins, so
      // an ack arriving in the abort cycle is simply discarded.
      ST_OWN0: if (!m0CycleStrobe || ackIn) state_d = ST_IDLE;
      ST_OWN1: if (!m1CycleStrobe || ackIn) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Bus muxing depends only on the registered state; no request-to-grant path.
  always_comb begin
    sWriteEnable = 1'b0;
    sAddress     = '0;
    sWriteData   = '0;
    if (own0) begin
      sWriteEnable = m0WriteEnable;
      sAddress     = m0Address;
      sWriteData   = m0WriteData;
    end else if (own1) begin
      sWriteEnable = m1WriteEnable;
      sAddress     = m1Address;
      sWriteData   = m1WriteData;
    end
  end

  assign sCycleStrobe = ownerStrobe;
  assign m0Ack        = own0 & m0CycleStrobe & ackIn;
  assign m1Ack        = own1 & m1CycleStrobe & ackIn;
  assign m0ReadData   = sReadData;
  assign m1ReadData   = sReadData;
  assign grant        = {own1, own0};

endmodule

// File: tb/tb_wb_ram_arbiter.sv
module tb_wb_ram_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;

  logic        m0CycleStrobe = 0, m0WriteEnable = 0;
  logic [31:0] m0Address = '0, m0WriteData = '0, m0ReadData;
  logic        m0Ack;
  logic        m1CycleStrobe = 0, m1WriteEnable = 0;
  logic [31:0] m1Address = '0, m1WriteData = '0, m1ReadData;
  logic        m1Ack;
  logic        sCycleStrobe, sWriteEnable;
  logic [31:0] sAddress, sWriteData, sReadData;
  logic        sAck;
  logic [1:0]  grant;
`ifdef WB_RAM_ARB_TIMEOUT_EN
  logic        timeoutError;
`endif

  // Slave side: toggle-ack RAM model, or a manually driven ack.
  logic        model_en   = 1'b1;
  logic        manual_ack = 1'b0;
  logic        ack_q;
  logic [31:0] rdata_q;
  logic [31:0] mem [0:255];

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  assign sAck      = model_en ? ack_q : manual_ack;
  assign sReadData = rdata_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else if (sCycleStrobe && !ack_q) begin
      ack_q   <= 1'b1;
      rdata_q <= mem[sAddress[7:0]];
      if (sWriteEnable) mem[sAddress[7:0]] <= sWriteData;
    end else begin
      ack_q <= 1'b0;
    end
  end

  wb_ram_arbiter #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .m0CycleStrobe (m0CycleStrobe),
    .m0WriteEnable (m0WriteEnable),
    .m0Address     (m0Address),
    .m0WriteData   (m0WriteData),
    .m0ReadData    (m0ReadData),
    .m0Ack         (m0Ack),
    .m1CycleStrobe (m1CycleStrobe),
    .m1WriteEnable (m1WriteEnable),
    .m1Address     (m1Address),
    .m1WriteData   (m1WriteData),
    .m1ReadData    (m1ReadData),
    .m1Ack         (m1Ack),
    .sCycleStrobe  (sCycleStrobe),
    .sWriteEnable  (sWriteEnable),
    .sAddress      (sAddress),
    .sWriteData    (sWriteData),
    .sReadData     (sReadData),
    .sAck          (sAck),
`ifdef WB_RAM_ARB_TIMEOUT_EN
    .timeoutError  (timeoutError),
`endif
    .grant         (grant)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Sample point: 1 time unit after the falling edge, far from the rising edge.
  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  // One transaction for master m; the strobe is held through the ack edge.
  task automatic xfer(input int m, input logic we, input logic [31:0] addr,
                      input logic [31:0] wd, output logic [31:0] rd,
                      output int ackMine, output int ackOther);
    bit done;
    done = 0; ackMine = 0; ackOther = 0; rd = '0;
    if (m == 0) begin
      m0WriteEnable = we; m0Address = addr; m0WriteData = wd; m0CycleStrobe = 1'b1;
    end else begin
      m1WriteEnable = we; m1Address = addr; m1WriteData = wd; m1CycleStrobe = 1'b1;
    end
    for (int i = 0; i < 20 && !done; i++) begin
      tick();
      if (m == 0) begin
        if (m0Ack) begin ackMine++; rd = m0ReadData; done = 1; end
        if (m1Ack) ackOther++;
      end else begin
        if (m1Ack) begin ackMine++; rd = m1ReadData; done = 1; end
        if (m0Ack) ackOther++;
      end
    end
    if (!done) check("xfer_ack_timeout", 0, 1);
    tick();
    if (m0Ack) begin if (m == 0) ackMine++; else ackOther++; end
    if (m1Ack) begin if (m == 1) ackMine++; else ackOther++; end
    m0CycleStrobe = 1'b0;
    m1CycleStrobe = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    int am, ao;

    // 1: reset with both strobes high, then master 0 priority
    m0CycleStrobe = 1; m1CycleStrobe = 1; m0WriteEnable = 1;
    m0Address = 32'h44;
    reset = 0;
    tick();
    check("rst_grant", grant, 2'b00);
    check("rst_sstb", sCycleStrobe, 0);
    check("rst_swe", sWriteEnable, 0);
    check("rst_m0ack", m0Ack, 0);
    check("rst_m1ack", m1Ack, 0);
    reset = 1;
    tick();
    check("rel_grant", grant, 2'b01);
    check("rel_sstb", sCycleStrobe, 1);
    check("rel_saddr", sAddress, 32'h44);
    m0CycleStrobe = 0; m1CycleStrobe = 0; m0WriteEnable = 0;
    tick();
    check("abort_idle", grant, 2'b00);
    check("idle_saddr", sAddress, 32'h0);

    // 2: m0 write, m1 read back
    do_reset();
    xfer(0, 1'b1, 32'h10, 32'hA5A5A5A5, rd, am, ao);
    check("wr_m0ack_cnt", am, 1);
    check("wr_m1ack_cnt", ao, 0);
    xfer(1, 1'b0, 32'h10, 32'h0, rd, am, ao);
    check("rd_m1ack_cnt", am, 1);
    check("rd_m0ack_cnt", ao, 0);
    check("rd_data", rd, 32'hA5A5A5A5);

    // 3: continuous requests alternate with an IDLE gap
    do_reset();
    m0CycleStrobe = 1; m1CycleStrobe = 1;
    m0Address = 32'h20; m1Address = 32'h24;
    for (int t = 0; t < 8; t++) begin
      logic [1:0] eg;
      eg = (t % 2 == 0) ? 2'b01 : 2'b10;
      tick();
      check("rr_grant_a", grant, eg);
      check("rr_acks_a", {m1Ack, m0Ack}, 2'b00);
      tick();
      check("rr_grant_b", grant, eg);
      check("rr_acks_b", {m1Ack, m0Ack}, eg);
      tick();
      check("rr_idle", grant, 2'b00);
      check("rr_acks_idle", {m1Ack, m0Ack}, 2'b00);
    end
    m0CycleStrobe = 0; m1CycleStrobe = 0;
    tick();

    // 4: m1 aborts in the same cycle sAck arrives
    model_en = 0; manual_ack = 0;
    do_reset();
    m1CycleStrobe = 1;
    tick();
    check("ab_grant1", grant, 2'b10);
    m1CycleStrobe = 0; m0CycleStrobe = 1; manual_ack = 1;
    #1;
    check("ab_no_m1ack", m1Ack, 0);
    check("ab_no_m0ack", m0Ack, 0);
    check("ab_sstb", sCycleStrobe, 0);
    tick();
    check("ab_idle", grant, 2'b00);
    check("ab_idle_ack", {m1Ack, m0Ack}, 2'b00);
    manual_ack = 0;
    tick();
    check("ab_m0_next", grant, 2'b01);
    m0CycleStrobe = 0;
    tick();

    // 5: async reset during OWN1
    do_reset();
    m1CycleStrobe = 1;
    tick();
    check("ar_own1", grant, 2'b10);
    check("ar_sstb_on", sCycleStrobe, 1);
    reset = 0;
    #1;
    check("ar_sstb_off", sCycleStrobe, 0);
    check("ar_grant_off", grant, 2'b00);
    m0CycleStrobe = 1;
    tick();
    check("ar_held", grant, 2'b00);
    reset = 1;
    tick();
    check("ar_tie_m0", grant, 2'b01);
    m0CycleStrobe = 0; m1CycleStrobe = 0;
    tick();

`ifdef WB_RAM_ARB_TIMEOUT_EN
    // 6: slave never acks -> timeout in the 5th OWN0 cycle
    do_reset();
    m0CycleStrobe = 1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      check("to_grant", grant, 2'b01);
      check("to_no_ack", m0Ack, 0);
      check("to_no_err", timeoutError, 0);
    end
    tick();
    check("to_ack", m0Ack, 1);
    check("to_err", timeoutError, 1);
    tick();
    check("to_idle", grant, 2'b00);
    check("to_err_clr", timeoutError, 0);
    m0CycleStrobe = 0;
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
